memory_reader: RTL and testbench
================================

# memory_reader

Read-side streamer for the Huffman coder's 12-bit × 64 word-addressable symbol/code memory. On a start command it walks a contiguous address range, drives the memory's read address and absorbs its one-cycle registered-address read latency. It delivers each word on a valid/ready output stream at up to one word per clock, and holds the memory address under backpressure so that no word is lost or duplicated. It sits between the shared memory port (read mode) and the coder datapath that consumes table entries.

## Interface
- DATA_WIDTH, 12, memory word and stream width
- ADDR_WIDTH, 6, memory address width (depth 2^ADDR_WIDTH = 64)
- clock  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle command; sampled only in IDLE
- base_addr  input  ADDR_WIDTH  first address to read; sampled with start
- count  input  ADDR_WIDTH+1  number of words, 0..64; sampled with start
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse after the last word handshake, or after a count=0 start
- mem_addr  output  ADDR_WIDTH  read address to memory (combinational)
- mem_data  input  DATA_WIDTH  memory read data, valid one cycle after address presented
- out_data  output  DATA_WIDTH  stream word (registered)
- out_valid  output  1  stream valid (registered)
- out_ready  input  1  consumer ready; transfer when out_valid && out_ready

## Operation
- The memory captures mem_addr on every rising edge while in read mode. mem_data reflects the address presented in the previous cycle. The integrator keeps memory modeselect low while busy is high.
- Internal state: ptr (ADDR_WIDTH), left (ADDR_WIDTH+1), FSM {IDLE, RUN, DRAIN}.
- IDLE: mem_addr = base_addr.
  - start with count ≠ 0: ptr ← base_addr, left ← count−1, go to RUN.
  - start with count = 0: pulse done next cycle, stay in IDLE, no data.
- RUN: mem_data holds ram[ptr].
  - advance = !out_valid || out_ready.
  - advance: out_data ← mem_data, out_valid ← 1, mem_addr = ptr+1. If left = 0, go to DRAIN; otherwise ptr ← ptr+1 and left ← left−1.
  - no advance: mem_addr = ptr, re-presenting the same address so mem_data stays stable.
- DRAIN: mem_addr = ptr (don't care).
  - out_valid && out_ready: out_valid ← 0, done ← 1, go to IDLE.
- ptr is ADDR_WIDTH wide and wraps modulo 64, so 0x3F+1 reads 0x00.
- Outside a final transfer in DRAIN, out_valid is cleared only by a handshake with no replacement word. In RUN the register reloads on advance, so out_valid stays high during back-to-back transfers.
- start while busy is ignored. base_addr and count are don't-care outside the start cycle.

## Timing
- Reset values (asynchronous, immediate): state IDLE, out_valid 0, out_data 0, busy 0, done 0, ptr 0, left 0. mem_addr follows base_addr.
- Start accepted at cycle 0 (rising edge ending cycle 0). The memory captures base_addr on the same edge.
- Word k is loaded at the end of cycle k+1 and is visible from cycle k+2 when out_ready is held high. First out_valid appears in cycle 2.
- Throughput is 1 word/cycle with out_ready high. For N words the last word is valid in cycle N+1, and done is high with busy low in cycle N+2. A new start is accepted in cycle N+2.
- Each stall cycle delays all later words and done by exactly one cycle. out_data and out_valid stay stable while out_valid && !out_ready.
- done is high for exactly one cycle. busy falls in the same cycle done rises.
- count = 0: done is high in cycle 1 and busy never rises.
- Reset mid-stream: outputs clear immediately. Any in-flight word is dropped and no done is produced.

## Test plan
- Memory preloaded with ram[i] = 0xA00+i. start base=0x05, count=4, out_ready=1 → out_data 0xA05, 0xA06, 0xA07, 0xA08 in cycles 2–5; done in cycle 6.
- Wrap: base=0x3E, count=4 → 0xA3E, 0xA3F, 0xA00, 0xA01; no gaps.
- Backpressure: count=3, out_ready low in cycles 3–5 → 0xA06 held for those cycles, no loss or duplication, done delayed by 3 cycles.
- Full depth: base=0x00, count=64, ready high → 64 consecutive words 0xA00..0xA3F in cycles 2–65, done in cycle 66. A start during busy has no effect.
- count=0 → done in cycle 1, out_valid never asserted, busy stays 0.
- Assert reset_n low while out_valid=1 mid-transfer → out_valid, busy and done are 0 immediately. A fresh start after release streams correctly from its base_addr.

Source files
------------

// File: rtl/memory_reader.sv
// Purpose : streams a contiguous, wrapping address range out of a registered-address
//           read memory onto a valid/ready word stream.
// Latency : first word valid two cycles after start; then one word per clock.
// Backpressure: the memory address is re-presented while the output is stalled, so
//           the pending read word stays stable and no word is lost or duplicated.
//
// Ports:
//   clock, reset_n        single clock, asynchronous active-low reset
//   start/base_addr/count command, sampled only while idle (count 0..2^ADDR_WIDTH)
//   busy, done            busy while streaming; one-cycle done pulse at completion
//   mem_addr, mem_data    memory read port (data returns one cycle after address)
//   out_data/out_valid/out_ready  registered output stream
module memory_reader #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   LEFT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   LEFT_ZERO = '0;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;        // address whose data is on mem_data in RUN
    logic [ADDR_WIDTH:0]     left_q, left_d;      // words still to fetch after the one at ptr
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_c;
    logic                    advance;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            left_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            left_q      <= left_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        left_d      = left_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        mem_addr_c  = ptr_q;
        // The output register may take a new word when empty or being drained this cycle.
        advance     = !out_valid_q || out_ready;

        case (state_q)
            S_IDLE: begin
                // Presenting base_addr while idle means the memory already holds
                // ram[base_addr] on the first RUN cycle.
                mem_addr_c = base_addr;
                if (start) begin
                    if (count != LEFT_ZERO) begin
                        ptr_d   = base_addr;
                        left_d  = count - LEFT_ONE;
                        state_d = S_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (advance) begin
                    out_data_d  = mem_data;
                    out_valid_d = 1'b1;
                    mem_addr_c  = ptr_q + ADDR_ONE;
                    if (left_q == LEFT_ZERO) begin
                        state_d = S_DRAIN;
                    end else begin
                        ptr_d  = ptr_q + ADDR_ONE;
                        left_d = left_q - LEFT_ONE;
                    end
                end
                // On a stall mem_addr stays at ptr, so mem_data keeps ram[ptr].
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign mem_addr  = mem_addr_c;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_memory_reader.sv
// Purpose : directed self-checking bench for memory_reader with a registered-address RAM model.
// Latency : expects first word in cycle 2 after start, one word per ready cycle, done after last.
// Backpressure: out_ready is dropped over chosen cycle windows; words must hold and resume in order.
module tb_memory_reader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  base_addr;
    logic [6:0]  count;
    logic        busy;
    logic        done;
    logic [5:0]  mem_addr;
    logic [11:0] mem_data;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;

    logic [11:0] ram [64];
    int n_checks = 0;
    int n_pass   = 0;

    memory_reader #(
        .DATA_WIDTH(12),
        .ADDR_WIDTH(6)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .base_addr(base_addr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    // Registered-address read memory: data for an address appears one cycle later.
    always_ff @(posedge clock) mem_data <= ram[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Start a transfer in cycle 0 and check every cycle until done.
    // out_ready is low for cycles st_lo..st_hi; a spurious start is driven in cycle spur.
    task automatic run(input logic [5:0] base, input logic [6:0] cnt,
                       input int st_lo, input int st_hi, input int spur);
        int          e;
        bit          seen;
        logic [5:0]  a;
        logic [11:0] exp_word;
        e    = 0;
        seen = 1'b0;
        start     = 1'b1;
        base_addr = base;
        count     = cnt;
        out_ready = 1'b1;
        #1;
        check("idle_mem_addr", 32'(mem_addr), 32'(base));
        check("idle_busy", 32'(busy), 32'd0);
        tick();
        for (int c = 1; c < 400 && !seen; c++) begin
            start     = (c == spur);
            base_addr = 6'h2A;
            count     = 7'd9;
            out_ready = !(c >= st_lo && c <= st_hi);
            #1;
            if (e < int'(cnt)) begin
                check("valid", 32'(out_valid), (c >= 2) ? 32'd1 : 32'd0);
                check("busy", 32'(busy), 32'd1);
                check("done_early", 32'(done), 32'd0);
                if (c >= 2) begin
                    a        = base + 6'(e);
                    exp_word = 12'hA00 + {6'd0, a};
                    check("data", 32'(out_data), 32'(exp_word));
                    if (out_ready) e++;
                end
            end else begin
                check("done", 32'(done), 32'd1);
                check("busy_at_done", 32'(busy), 32'd0);
                check("valid_at_done", 32'(out_valid), 32'd0);
                seen = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        if (!seen) check("timeout_done", 32'd0, 32'd1);
        check("done_pulse_width", 32'(done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 12'hA00 + 12'(i);
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = 6'h11;
        count     = 7'd0;
        out_ready = 1'b1;
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h11);
        reset_n = 1'b1;
        tick();

        run(6'h05, 7'd4, 0, -1, -1);     // basic, words in cycles 2..5, done 6
        run(6'h3E, 7'd4, 0, -1, -1);     // wrap 0x3F -> 0x00
        run(6'h05, 7'd3, 3, 5, -1);      // backpressure cycles 3..5, done in 8
        run(6'h00, 7'd64, 0, -1, 10);    // full depth with start while busy
        run(6'h09, 7'd0, 0, -1, -1);     // empty: done in cycle 1 only

        // Reset in the middle of a stream.
        start     = 1'b1;
        base_addr = 6'h10;
        count     = 7'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        run(6'h30, 7'd5, 4, 4, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
